scramble_stream: RTL

Parametrised BLE data whitening/de-whitening engine: x^7+x^4+1 LFSR seeded from the channel index, processing DATA_WIDTH bits per beat behind valid/ready handshakes on both sides. It sits between the packet assembler and the GFSK modulator on TX, and between the bit slicer and the CRC checker on RX. It adds framing (last), per-packet seed auto-reload, bypass, and backpressure over the single-bit scrambler.

---
 rtl/scramble_stream.sv | 105 ++++++++++
 1 files changed

// File: rtl/scramble_stream.sv
// BLE data whitening / de-whitening engine.
// x^7+x^4+1 style Galois LFSR seeded from the bit-reversed channel index.
// Processes DATA_WIDTH bits per beat (LSB first in air time) with valid/ready
// on both sides, per-packet seed reload on the last beat, and per-beat bypass.
module scramble_stream #(
    parameter int unsigned CHANNEL_NUMBER_BIT_WIDTH = 6,
    parameter int unsigned DATA_WIDTH               = 8,
    parameter logic [CHANNEL_NUMBER_BIT_WIDTH:0] POLY = 7'b0010000
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] channel_number,
    input  logic                                channel_number_load,
    input  logic                                bypass,
    input  logic [DATA_WIDTH-1:0]               data_in,
    input  logic                                data_in_valid,
    input  logic                                data_in_last,
    output logic                                data_in_ready,
    output logic [DATA_WIDTH-1:0]               data_out,
    output logic                                data_out_last,
    output logic                                data_out_valid,
    input  logic                                data_out_ready
);

    localparam int unsigned L = CHANNEL_NUMBER_BIT_WIDTH + 1;
    // Reset seed: stage 0 set, all others clear.
    localparam logic [L-1:0] SEED_RST = L'(1);
    // Stage 0 always takes the feedback bit directly, so POLY bit 0 is ignored.
    localparam logic [L-1:0] TAPS = POLY & ~L'(1);

    logic [L-1:0]          seed_q;
    logic [L-1:0]          lfsr_q;
    logic [L-1:0]          lfsr_d;
    logic [L-1:0]          seed_c;
    logic [L-1:0]          lfsr_adv;
    logic [DATA_WIDTH-1:0] keystream;
    logic                  accept;

    // Upstream may hand over a beat only when the output slot frees this cycle and no load is in progress.
    assign data_in_ready = !channel_number_load && (!data_out_valid || data_out_ready);
    assign accept        = data_in_valid && data_in_ready;

    // Seed mapping: stage 0 forced high, stages 1..L-1 take the channel bits in reversed order.
    always_comb begin
        seed_c = SEED_RST;
        for (int unsigned j = 1; j < L; j++) begin
            seed_c[j] = channel_number[CHANNEL_NUMBER_BIT_WIDTH - j];
        end
    end

    // Unrolled DATA_WIDTH LFSR steps: keystream bit k is the top stage before step k.
    always_comb begin
        logic [L-1:0] walk;
        walk      = lfsr_q;
        keystream = '0;
        for (int unsigned k = 0; k < DATA_WIDTH; k++) begin
            keystream[k] = walk[L-1];
            walk = {walk[L-2:0], walk[L-1]} ^ (TAPS & {L{walk[L-1]}});
        end
        lfsr_adv = walk;
    end

    // LFSR next state: load beats everything; a last beat restarts from the seed; bypass freezes.
    always_comb begin
        lfsr_d = lfsr_q;
        if (channel_number_load) begin
            lfsr_d = seed_c;
        end else if (accept) begin
            if (data_in_last) begin
                lfsr_d = seed_q;
            end else if (!bypass) begin
                lfsr_d = lfsr_adv;
            end
        end
    end

    // Seed and LFSR registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seed_q <= SEED_RST;
            lfsr_q <= SEED_RST;
        end else begin
            if (channel_number_load) begin
                seed_q <= seed_c;
            end
            lfsr_q <= lfsr_d;
        end
    end

    // Output slot: capture on accept, drop valid once downstream takes it, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out       <= '0;
            data_out_last  <= 1'b0;
            data_out_valid <= 1'b0;
        end else if (accept) begin
            data_out       <= bypass ? data_in : (data_in ^ keystream);
            data_out_last  <= data_in_last;
            data_out_valid <= 1'b1;
        end else if (data_out_ready) begin
            data_out_valid <= 1'b0;
        end
    end

endmodule
